calc_sequencer: RTL
===================

# calc_sequencer

Sequencing controller for the switch-driven calculator datapath. It debounces the front-panel buttons and steps the operator through operand A entry, operand B entry and operation select. It drives the captured operands into the XOR/AND/OR/SUM/DIF units and latches the selected unit's result into a held, registered answer for the display. It sits between the board I/O (switches, buttons) and the combinational arithmetic units.

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz); minimum 2.
- `clk` in 1: system clock; every register in the block is clocked on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btnr` in 1: raw "advance" button, asynchronous to `clk`.
- `btnl` in 1: raw "abort" button, asynchronous to `clk`.
- `sw` in 8: operand entry switches.
- `op` in 3: operation select switches.
- `xor_in` in 8: result from the XOR unit.
- `and_in` in 8: result from the AND unit.
- `or_in` in 8: result from the OR unit.
- `sum_in` in 10: result from the SUM unit.
- `dif_in` in 8: result from the DIF unit.
- `num1` out 8: registered operand A, driven to all units.
- `num2` out 8: registered operand B, driven to all units.
- `state` out 3: current FSM state encoding, for display prompts.
- `ans` out 10: registered held answer.
- `ans_valid` out 1: high while `ans` holds a computed result.
- `op_err` out 1: high with `ans_valid` when the captured op code is unused.

## Operation
- Button path, per button: 2-flop synchronizer, then a stability counter, then a registered rising-edge pulse.
  - The counter increments while the synchronized level differs from the debounced level.
  - The counter clears whenever the two levels match.
  - On reaching `DB_CYCLES` consecutive mismatches, the debounced level toggles and the counter clears.
  - A press is a one-cycle pulse when the debounced level rises. Release produces no pulse.
- FSM states, each with its own encoding:
  - S_A (0): on press, `num1`←`sw`; go to S_B.
  - S_B (1): on press, `num2`←`sw`; go to S_OP.
  - S_OP (2): on press, `op_r`←`op`; go to S_CALC.
  - S_CALC (3): unconditional single cycle. `ans`←selected result, `ans_valid`←1, `op_err`←(op_r>4). Go to S_SHOW.
  - S_SHOW (4): `ans` is held. On press, `ans_valid`←0 and `op_err`←0; go to S_A. `num1`/`num2` retain their values until overwritten.
- Op codes: 000 XOR, 001 AND, 010 OR, 011 SUM, 100 DIF. Codes 101–111 give `ans`=0 and `op_err`=1.
- Width rule: 8-bit results are zero-extended to 10 bits; `sum_in` passes through unchanged.
- Abort press, in any state: go to S_A; `ans`, `ans_valid` and `op_err` clear. `num1`/`num2` are kept.
- Abort and advance pulses in the same cycle: abort wins and the advance press is discarded.
- Presses arriving during S_CALC are ignored.
- Switch changes outside a capture edge have no effect on outputs.

## Timing
- Reset values: `num1`=0, `num2`=0, `op_r`=0, `ans`=0, `ans_valid`=0, `op_err`=0, `state`=S_A. Debounced levels are 0 and counters are 0.
- Reset asserted mid-sequence returns to S_A immediately, asynchronously. Operation resumes on the first edge after deassertion.
- Raw button rising before edge N and held: the internal press pulse is high during cycle N+`DB_CYCLES`+2. The FSM register updates at the following edge, N+`DB_CYCLES`+3.
- Glitches shorter than `DB_CYCLES` cycles produce no press.
- Operand capture latency: 1 cycle after the press pulse.
- Answer latency: `ans`/`ans_valid` update exactly 2 edges after the S_OP press pulse.
- Arithmetic inputs are sampled only in S_CALC. Later changes to the unit outputs do not alter `ans`.

## Structure
- Shared package `calc_pkg` holds:
  - state encodings S_A..S_SHOW;
  - op codes OP_XOR..OP_DIF;
  - `ANS_W`=10 and `OPND_W`=8.
- Sub-module `btn_debounce` (parameter `DB_CYCLES`; ports `clk`, `rst_n`, raw, `press`) is instantiated twice, once for `btnr` and once for `btnl`.
- The top level contains the FSM, the operand/op registers and the result mux/latch.

## Test plan
All scenarios use `DB_CYCLES`=4.
- Full sequence: `sw`=0x0F press, `sw`=0x3C press, `op`=000 press → `num1`=0x0F, `num2`=0x3C, `ans`=0x033 with `ans_valid`=1 exactly 2 edges after the third press pulse.
- SUM width: operands 0xFF and 0xFF, `op`=011, `sum_in`=0x1FE → `ans`=0x1FE. Then change `sum_in` to 0 → `ans` stays 0x1FE.
- Bounce filter: `btnr` pulses of 3 cycles repeated 5 times → `state` stays 0. A 10-cycle hold → exactly one advance, with `state`=1 at edge N+7.
- Illegal op: `op`=110 → `ans`=0, `op_err`=1, `ans_valid`=1. An advance press in S_SHOW → `state`=0, `ans_valid`=0, `op_err`=0.
- Abort priority: `btnl` and `btnr` released into the debouncers in the same cycle while in S_B → `state`=0, `num2` unchanged.
- Async reset in S_SHOW with `ans`=0x033 → all outputs 0 and `state`=0 before the next clock edge.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the calculator sequencer: FSM state encodings, op codes and datapath widths.
package calc_pkg;

  localparam int unsigned ANS_W  = 10;
  localparam int unsigned OPND_W = 8;

  localparam logic [2:0] S_A    = 3'd0;
  localparam logic [2:0] S_B    = 3'd1;
  localparam logic [2:0] S_OP   = 3'd2;
  localparam logic [2:0] S_CALC = 3'd3;
  localparam logic [2:0] S_SHOW = 3'd4;

  localparam logic [2:0] OP_XOR = 3'd0;
  localparam logic [2:0] OP_AND = 3'd1;
  localparam logic [2:0] OP_OR  = 3'd2;
  localparam logic [2:0] OP_SUM = 3'd3;
  localparam logic [2:0] OP_DIF = 3'd4;

  function automatic logic [ANS_W-1:0] zext(input logic [OPND_W-1:0] v);
    return {{(ANS_W-OPND_W){1'b0}}, v};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, registered one-cycle press pulse.
module btn_debounce #(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam int unsigned CW = $clog2(DB_CYCLES + 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          db_dly_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Level toggles after DB_CYCLES consecutive mismatching cycles; any match restarts the count.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      db_q     <= db_d;
      db_dly_q <= db_q;
      press_q  <= db_q & ~db_dly_q;
      cnt_q    <= cnt_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator sequencer: debounced advance/abort buttons step through operand A, operand B, op select,
// then latch the selected arithmetic unit's result into a held answer.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btnr,
  input  logic              btnl,
  input  logic [OPND_W-1:0] sw,
  input  logic [2:0]        op,
  input  logic [OPND_W-1:0] xor_in,
  input  logic [OPND_W-1:0] and_in,
  input  logic [OPND_W-1:0] or_in,
  input  logic [ANS_W-1:0]  sum_in,
  input  logic [OPND_W-1:0] dif_in,
  output logic [OPND_W-1:0] num1,
  output logic [OPND_W-1:0] num2,
  output logic [2:0]        state,
  output logic [ANS_W-1:0]  ans,
  output logic              ans_valid,
  output logic              op_err
);

  logic adv_p, abort_p;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_adv (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btnr),
    .press (adv_p)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_abort (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btnl),
    .press (abort_p)
  );

  logic [2:0]        state_q, state_d;
  logic [OPND_W-1:0] num1_q, num1_d, num2_q, num2_d;
  logic [2:0]        op_q, op_d;
  logic [ANS_W-1:0]  ans_q, ans_d, result;
  logic              valid_q, valid_d, err_q, err_d;

  always_comb begin
    case (op_q)
      OP_XOR:  result = zext(xor_in);
      OP_AND:  result = zext(and_in);
      OP_OR:   result = zext(or_in);
      OP_SUM:  result = sum_in;
      OP_DIF:  result = zext(dif_in);
      default: result = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    num1_d  = num1_q;
    num2_d  = num2_q;
    op_d    = op_q;
    ans_d   = ans_q;
    valid_d = valid_q;
    err_d   = err_q;
    // Abort overrides everything, including a coincident advance and the S_CALC cycle.
    if (abort_p) begin
      state_d = S_A;
      ans_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_A:    if (adv_p) begin num1_d = sw; state_d = S_B;    end
        S_B:    if (adv_p) begin num2_d = sw; state_d = S_OP;   end
        S_OP:   if (adv_p) begin op_d   = op; state_d = S_CALC; end
        S_CALC: begin
          ans_d   = result;
          valid_d = 1'b1;
          err_d   = (op_q > OP_DIF);
          state_d = S_SHOW;
        end
        S_SHOW: if (adv_p) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_A;
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_A;
      num1_q  <= '0;
      num2_q  <= '0;
      op_q    <= '0;
      ans_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num1_q  <= num1_d;
      num2_q  <= num2_d;
      op_q    <= op_d;
      ans_q   <= ans_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign num1      = num1_q;
  assign num2      = num2_q;
  assign state     = state_q;
  assign ans       = ans_q;
  assign ans_valid = valid_q;
  assign op_err    = err_q;

endmodule
